// File: rtl/arcade_input_pkg.sv
// Shared definitions for the arcade input mapper: button indices, the unused-key
// marker, the default 2-player keyboard table and the parameter legality check.
package arcade_input_pkg;

    localparam int BTN_RIGHT = 0;
    localparam int BTN_LEFT  = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_UP    = 3;
    localparam int BTN_FIRE1 = 4;
    localparam int BTN_FIRE2 = 5;
    localparam int BTN_START = 6;
    localparam int BTN_COIN  = 7;

    localparam logic [8:0] KEY_UNUSED = 9'h1FF;

    // Entry p*8+b sits at bits [(p*8+b)*9 +: 9]; listed MSB first (P2 coin .. P1 right).
    localparam logic [143:0] DEFAULT_KEYMAP = {
        9'h036, 9'h01E, 9'h01B, 9'h01C, 9'h034, 9'h023, 9'h02B, 9'h02D,
        9'h02E, 9'h016, 9'h014, 9'h029, 9'h075, 9'h072, 9'h06B, 9'h074
    };

    function automatic bit params_ok(input int players, input int buttons,
                                     input logic [23:0] af_div);
        return (players >= 1) && (players <= 4) &&
               (buttons >= 8) && (buttons <= 12) &&
               (af_div >= 24'd2);
    endfunction

endpackage

// File: rtl/arcade_input_mapper_coin_stretch.sv
// Coin pulse stretcher: holds the output high for at least COIN_CYCLES cycles
// after each rising edge of din; COIN_CYCLES of zero passes din straight through.
module coin_stretch #(
    parameter logic [23:0] COIN_CYCLES = 24'd500000
)(
    input  logic clk_sys,
    input  logic reset,
    input  logic din,
    output logic dout
);

    if (COIN_CYCLES == 24'd0) begin : g_bypass
        logic unused_s;
        assign unused_s = clk_sys ^ reset;
        assign dout     = din;
    end else begin : g_stretch
        logic [23:0] cnt_r;
        logic        din_d_r;

        // Edge detect and hold counter; a new edge while active reloads the count.
        always_ff @(posedge clk_sys) begin
            if (reset) begin
                cnt_r   <= 24'd0;
                din_d_r <= 1'b0;
            end else begin
                din_d_r <= din;
                if (din && !din_d_r) begin
                    cnt_r <= COIN_CYCLES - 24'd1;
                end else if (cnt_r != 24'd0) begin
                    cnt_r <= cnt_r - 24'd1;
                end else begin
                    cnt_r <= cnt_r;
                end
            end
        end

        assign dout = din | (cnt_r != 24'd0);
    end

endmodule

// File: rtl/arcade_input_mapper.sv
// Player-input front end: decodes the hps_io PS/2 stream through a keyboard table,
// merges joysticks, stretches coin pulses, applies autofire, registers the result.
module arcade_input_mapper
    import arcade_input_pkg::*;
#(
    parameter int                             PLAYERS      = 2,
    parameter int                             BUTTONS      = 8,
    parameter logic [PLAYERS*BUTTONS*9-1:0]   KEYMAP       = DEFAULT_KEYMAP,
    parameter logic [23:0]                    COIN_CYCLES  = 24'd500000,
    parameter logic [23:0]                    AUTOFIRE_DIV = 24'd2000000
)(
    input  logic                         clk_sys,
    input  logic                         reset,
    input  logic [10:0]                  ps2_key,
    input  logic [PLAYERS*16-1:0]        joystick,
    input  logic [BUTTONS-1:0]           autofire_en,
    output logic [PLAYERS*BUTTONS-1:0]   joy_out
);

    localparam int ENTRIES = PLAYERS * BUTTONS;

    if (!params_ok(PLAYERS, BUTTONS, AUTOFIRE_DIV)) begin : g_param_check
        $error("arcade_input_mapper: PLAYERS, BUTTONS or AUTOFIRE_DIV out of range");
    end

    logic               old_toggle_r;
    logic               key_event_s;
    logic [ENTRIES-1:0] key_state_r;
    logic [ENTRIES-1:0] key_next_s;
    logic [ENTRIES-1:0] raw_s;
    logic [ENTRIES-1:0] mapped_s;
    logic [PLAYERS-1:0] coin_s;
    logic [23:0]        af_cnt_r;
    logic               af_phase_r;
    logic               unused_s;

    assign unused_s    = ^{joystick, autofire_en};
    assign key_event_s = (old_toggle_r != ps2_key[10]);

    // Keyboard table lookup; unused entries never match, duplicates all update.
    always_comb begin
        key_next_s = key_state_r;
        for (int i = 0; i < ENTRIES; i++) begin
            if (key_event_s && (KEYMAP[i*9 +: 9] != KEY_UNUSED) &&
                (KEYMAP[i*9 +: 9] == ps2_key[8:0])) begin
                key_next_s[i] = ps2_key[9];
            end else begin
                key_next_s[i] = key_state_r[i];
            end
        end
    end

    // Key state and toggle history; reset captures the live toggle to avoid a stale event.
    always_ff @(posedge clk_sys) begin
        old_toggle_r <= ps2_key[10];
        if (reset) begin
            key_state_r <= '0;
        end else begin
            key_state_r <= key_next_s;
        end
    end

    // Raw buttons: held keys OR the matching joystick bits.
    always_comb begin
        raw_s = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            for (int b = 0; b < BUTTONS; b++) begin
                raw_s[p*BUTTONS+b] = key_state_r[p*BUTTONS+b] | joystick[p*16+b];
            end
        end
    end

    for (genvar p = 0; p < PLAYERS; p++) begin : g_coin
        coin_stretch #(
            .COIN_CYCLES (COIN_CYCLES)
        ) u_coin (
            .clk_sys (clk_sys),
            .reset   (reset),
            .din     (raw_s[p*BUTTONS+BTN_COIN]),
            .dout    (coin_s[p])
        );
    end

    // Free-running autofire square wave, global to all players.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            af_cnt_r   <= 24'd0;
            af_phase_r <= 1'b0;
        end else if (af_cnt_r == AUTOFIRE_DIV - 24'd1) begin
            af_cnt_r   <= 24'd0;
            af_phase_r <= ~af_phase_r;
        end else begin
            af_cnt_r   <= af_cnt_r + 24'd1;
            af_phase_r <= af_phase_r;
        end
    end

    // Final per-button selection: coin from the stretcher, autofire except start/coin.
    always_comb begin
        mapped_s = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            for (int b = 0; b < BUTTONS; b++) begin
                if (b == BTN_COIN) begin
                    mapped_s[p*BUTTONS+b] = coin_s[p];
                end else if ((b != BTN_START) && autofire_en[b] && raw_s[p*BUTTONS+b]) begin
                    mapped_s[p*BUTTONS+b] = af_phase_r;
                end else begin
                    mapped_s[p*BUTTONS+b] = raw_s[p*BUTTONS+b];
                end
            end
        end
    end

    // Output register.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            joy_out <= '0;
        end else begin
            joy_out <= mapped_s;
        end
    end

endmodule
